// File: rtl/branch_predictor.sv
// Dynamic branch predictor for a 5-stage MIPS pipeline.
// IF: direct-mapped BTB lookup with 2-bit saturating counters gives the next PC.
// ID/EXE: the predicted next PC travels with the instruction. EXE compares it
// with the resolved next PC, flags a misprediction and trains the table.
// Optional statistics counters are enabled with the BP_STATS_EN macro.
//
// Handshake note: there is no valid/ready flow here. The pipeline controller
// owns the stage enables/resets, and exe_valid qualifies the EXE inputs. When
// exe_valid=0, predict_wrong is 0 and no training occurs.
module branch_predictor #(
  parameter int         INDEX_BITS = 4,
  parameter logic [1:0] CNT_INIT   = 2'b01,
  parameter logic [1:0] CNT_ALLOC  = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_if,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        id_en,
  input  logic        id_rst,
  input  logic        exe_en,
  input  logic        exe_rst,
  input  logic        exe_valid,
  input  logic        is_branch_exe,
  input  logic [31:0] pc_exe,
  input  logic        taken_exe,
  input  logic [31:0] target_exe,
  output logic        predict_wrong,
  output logic [31:0] correct_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 32 - INDEX_BITS - 2;

  logic             tbl_valid  [ENTRIES];
  logic [TAG_W-1:0] tbl_tag    [ENTRIES];
  logic [31:0]      tbl_target [ENTRIES];
  logic [1:0]       tbl_cnt    [ENTRIES];

  // The predicted next PC alone is carried down the pipe: comparing it with
  // the resolved next PC covers both direction and target errors, so a
  // separate taken bit would never be read.
  logic [31:0] id_pred_target;
  logic [31:0] exe_pred_target;

  logic [INDEX_BITS-1:0] if_idx;
  logic [TAG_W-1:0]      if_tag;
  logic                  if_hit;
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_W-1:0]      ex_tag;
  logic                  ex_hit;
  logic [31:0]           act_next;
  logic                  train;

  assign if_idx = pc_if[INDEX_BITS+1:2];
  assign if_tag = pc_if[31:INDEX_BITS+2];
  assign ex_idx = pc_exe[INDEX_BITS+1:2];
  assign ex_tag = pc_exe[31:INDEX_BITS+2];

  // IF lookup reads the registered table, so a same-cycle update is seen next cycle.
  always_comb begin
    if_hit         = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);
    predict_taken  = if_hit && tbl_cnt[if_idx][1];
    predict_target = predict_taken ? tbl_target[if_idx] : (pc_if + 32'd4);
  end

  // EXE resolution: real next PC against the carried prediction.
  always_comb begin
    ex_hit        = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);
    act_next      = (is_branch_exe && taken_exe) ? target_exe : (pc_exe + 32'd4);
    predict_wrong = !rst && exe_valid && (exe_pred_target != act_next);
    correct_pc    = act_next;
    train         = exe_valid && exe_en && !rst;
  end

  // BTB table: reset, counter training, allocation and alias invalidation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_cnt[i]   <= CNT_INIT;
      end
    end else if (train) begin
      if (is_branch_exe) begin
        if (ex_hit) begin
          if (taken_exe) begin
            tbl_target[ex_idx] <= target_exe;
            if (tbl_cnt[ex_idx] != 2'b11) tbl_cnt[ex_idx] <= tbl_cnt[ex_idx] + 2'b01;
          end else if (tbl_cnt[ex_idx] != 2'b00) begin
            tbl_cnt[ex_idx] <= tbl_cnt[ex_idx] - 2'b01;
          end
        end else if (taken_exe) begin
          tbl_valid[ex_idx]  <= 1'b1;
          tbl_tag[ex_idx]    <= ex_tag;
          tbl_target[ex_idx] <= target_exe;
          tbl_cnt[ex_idx]    <= CNT_ALLOC;
        end
      end else if (ex_hit) begin
        // A non-branch hit means an alias predicted taken; drop that entry.
        tbl_valid[ex_idx] <= 1'b0;
      end
    end
  end

  // Prediction tracking through ID and EXE (rst > stage reset > stage enable).
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pred_target  <= 32'd0;
      exe_pred_target <= 32'd0;
    end else begin
      if (id_rst)      id_pred_target <= 32'd0;
      else if (id_en)  id_pred_target <= predict_target;
      if (exe_rst)     exe_pred_target <= 32'd0;
      else if (exe_en) exe_pred_target <= id_pred_target;
    end
  end

`ifdef BP_STATS_EN
  // Saturating branch and misprediction counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (train && is_branch_exe && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (predict_wrong && exe_en && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vectors, a behavioural model checked
// every cycle on the falling edge, and hand-computed literal checks.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        id_en, id_rst, exe_en, exe_rst;
  logic        exe_valid, is_branch_exe, taken_exe;
  logic [31:0] pc_exe, target_exe;
  logic        predict_wrong;
  logic [31:0] correct_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  branch_predictor dut (
    .clk(clk), .rst(rst), .pc_if(pc_if),
    .predict_taken(predict_taken), .predict_target(predict_target),
    .id_en(id_en), .id_rst(id_rst), .exe_en(exe_en), .exe_rst(exe_rst),
    .exe_valid(exe_valid), .is_branch_exe(is_branch_exe), .pc_exe(pc_exe),
    .taken_exe(taken_exe), .target_exe(target_exe),
    .predict_wrong(predict_wrong), .correct_pc(correct_pc)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];
  logic [31:0] m_id_next, m_exe_next;   // predicted next PC held in ID / EXE
  logic [31:0] m_br, m_mis;
  bit          live = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit hit_of(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == int'(pc >> 6));
  endfunction

  // Compare outputs against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    logic        e_taken, e_wrong;
    logic [31:0] e_target, act;
    int          ei;
    e_taken  = hit_of(pc_if) && (m_cnt[idx_of(pc_if)] >= 2);
    e_target = e_taken ? m_tgt[idx_of(pc_if)] : pc_if + 32'd4;
    act      = (is_branch_exe && taken_exe) ? target_exe : pc_exe + 32'd4;
    e_wrong  = !rst && exe_valid && (m_exe_next != act);
    if (live) begin
      check("model predict_taken", {31'd0, predict_taken}, {31'd0, e_taken});
      check("model predict_target", predict_target, e_target);
      check("model predict_wrong", {31'd0, predict_wrong}, {31'd0, e_wrong});
      check("model correct_pc", correct_pc, act);
`ifdef BP_STATS_EN
      check("model stat_branches", stat_branches, m_br);
      check("model stat_mispredicts", stat_mispredicts, m_mis);
`endif
    end
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0;
        m_cnt[i]   = 1;
      end
      m_id_next  = 0;
      m_exe_next = 0;
      m_br       = 0;
      m_mis      = 0;
      live       = 1;
    end else begin
      if (e_wrong && exe_en && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
      if (exe_valid && exe_en) begin
        ei = idx_of(pc_exe);
        if (is_branch_exe) begin
          if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
          if (hit_of(pc_exe)) begin
            if (taken_exe) begin
              m_cnt[ei] = (m_cnt[ei] == 3) ? 3 : m_cnt[ei] + 1;
              m_tgt[ei] = target_exe;
            end else begin
              m_cnt[ei] = (m_cnt[ei] == 0) ? 0 : m_cnt[ei] - 1;
            end
          end else if (taken_exe) begin
            m_valid[ei] = 1;
            m_tag[ei]   = int'(pc_exe >> 6);
            m_tgt[ei]   = target_exe;
            m_cnt[ei]   = 2;
          end
        end else if (hit_of(pc_exe)) begin
          m_valid[ei] = 0;
        end
      end
      if (exe_rst)     m_exe_next = 0;
      else if (exe_en) m_exe_next = m_id_next;
      if (id_rst)      m_id_next = 0;
      else if (id_en)  m_id_next = e_target;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pcif, input logic v, input logic br,
                       input logic [31:0] pe, input logic tk, input logic [31:0] tg);
    pc_if = pcif; exe_valid = v; is_branch_exe = br;
    pc_exe = pe; taken_exe = tk; target_exe = tg;
  endtask

  // Directed table: ctl = {id_en, exe_en, exe_valid, is_branch, taken}.
  logic [4:0]  t_ctl  [12] = '{5'b11000, 5'b11000, 5'b11111, 5'b11111, 5'b11111, 5'b11100,
                               5'b10110, 5'b11110, 5'b01110, 5'b11110, 5'b11111, 5'b11000};
  logic [31:0] t_pcif [12] = '{32'h8, 32'h8, 32'h48, 32'h8, 32'h200, 32'h8,
                               32'h8, 32'h48, 32'h8, 32'h8, 32'h8, 32'h8};
  logic [31:0] t_pe   [12] = '{32'h0, 32'h0, 32'h8, 32'h8, 32'h48, 32'h10,
                               32'h8, 32'h8, 32'h8, 32'h200, 32'h48, 32'h0};
  logic [31:0] t_tg   [12] = '{32'h0, 32'h0, 32'h300, 32'h300, 32'h500, 32'h0,
                               32'h0, 32'h0, 32'h0, 32'h0, 32'h600, 32'h0};

  initial begin
    rst = 1; id_en = 1; id_rst = 0; exe_en = 1; exe_rst = 0;
    drive(32'h0, 0, 0, 32'h0, 0, 32'h0);
    tick(); tick();
    rst = 0;
    // c0: empty table
    drive(32'h40, 0, 0, 32'h0, 0, 32'h0); #1;
    check("reset predict_taken", {31'd0, predict_taken}, 32'd0);
    check("reset predict_target", predict_target, 32'h44);
    tick();
    // c1
    drive(32'h100, 0, 0, 32'h0, 0, 32'h0); tick();
    // c2: taken beq at 0x40 with no entry
    drive(32'h40, 1, 1, 32'h40, 1, 32'h80); #1;
    check("first beq predict_wrong", {31'd0, predict_wrong}, 32'd1);
    check("first beq correct_pc", correct_pc, 32'h80);
    check("same-cycle lookup old", {31'd0, predict_taken}, 32'd0);
    tick();
    // c3: allocated entry visible
    drive(32'h40, 0, 0, 32'h0, 0, 32'h0); #1;
    check("alloc predict_taken", {31'd0, predict_taken}, 32'd1);
    check("alloc predict_target", predict_target, 32'h80);
    tick();
    // c4
    drive(32'h40, 0, 0, 32'h0, 0, 32'h0); tick();
    // c5..c7: loop branch taken three times
    for (int i = 0; i < 3; i++) begin
      drive(32'h40, 1, 1, 32'h40, 1, 32'h80); #1;
      check("loop taken predict_wrong", {31'd0, predict_wrong}, 32'd0);
      tick();
    end
    // c8: loop exit
    drive(32'h40, 1, 1, 32'h40, 0, 32'h0); #1;
    check("loop exit predict_wrong", {31'd0, predict_wrong}, 32'd1);
    check("loop exit correct_pc", correct_pc, 32'h44);
    tick();
    // c9: counter 2 still predicts taken
    drive(32'h40, 0, 0, 32'h0, 0, 32'h0); #1;
    check("after exit predict_taken", {31'd0, predict_taken}, 32'd1);
    check("after exit predict_target", predict_target, 32'h80);
    tick();
    // c10: same index, different tag
    drive(32'h80, 0, 0, 32'h0, 0, 32'h0); #1;
    check("alias lookup predict_taken", {31'd0, predict_taken}, 32'd0);
    check("alias lookup predict_target", predict_target, 32'h84);
    tick();
    // c11: non-branch at hitting PC
    drive(32'h40, 1, 0, 32'h40, 0, 32'h0); #1;
    check("alias exe predict_wrong", {31'd0, predict_wrong}, 32'd1);
    check("alias exe correct_pc", correct_pc, 32'h44);
    tick();
    // c12: entry invalidated
    drive(32'h40, 0, 0, 32'h0, 0, 32'h0); #1;
    check("invalidated predict_taken", {31'd0, predict_taken}, 32'd0);
    check("invalidated predict_target", predict_target, 32'h44);
    tick();
    // c13: fetch 0x200 -> ID holds 0x204
    drive(32'h200, 0, 0, 32'h0, 0, 32'h0); tick();
    // c14, c15: ID stalled, EXE flushed
    id_en = 0; exe_rst = 1;
    drive(32'h40, 0, 0, 32'h0, 0, 32'h0); #1;
    check("stall predict_wrong", {31'd0, predict_wrong}, 32'd0);
    tick();
    drive(32'h40, 1, 0, 32'hFFFF_FFFC, 0, 32'h0); #1;
    check("flushed exe cleared", {31'd0, predict_wrong}, 32'd0);
    tick();
    // c16: release; EXE still cleared this cycle
    id_en = 1; exe_rst = 0;
    drive(32'h40, 1, 0, 32'hFFFF_FFFC, 0, 32'h0); #1;
    check("release exe cleared", {31'd0, predict_wrong}, 32'd0);
    tick();
    // c17: held prediction 0x204 reaches EXE
    drive(32'h40, 1, 0, 32'h200, 0, 32'h0); #1;
    check("held pred predict_wrong", {31'd0, predict_wrong}, 32'd0);
    tick();
    // c18: taken branch at 0x200
    drive(32'h40, 1, 1, 32'h200, 1, 32'h280); #1;
    check("branch 0x200 predict_wrong", {31'd0, predict_wrong}, 32'd1);
    check("branch 0x200 correct_pc", correct_pc, 32'h280);
    tick();
    // c19
    drive(32'h200, 0, 0, 32'h0, 0, 32'h0); #1;
    check("0x200 predict_target", predict_target, 32'h280);
    tick();
    // c20: mid-operation reset
    rst = 1;
    drive(32'h200, 1, 1, 32'h200, 1, 32'h999); #1;
    check("rst predict_wrong", {31'd0, predict_wrong}, 32'd0);
    tick();
    rst = 0;
    drive(32'h200, 0, 0, 32'h0, 0, 32'h0); #1;
    check("post rst predict_taken", {31'd0, predict_taken}, 32'd0);
    check("post rst predict_target", predict_target, 32'h204);
`ifdef BP_STATS_EN
    check("post rst stat_branches", stat_branches, 32'd0);
    check("post rst stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    tick();
    // Directed table, model-checked each cycle.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 12; i++) begin
        id_en  = t_ctl[i][4];
        exe_en = t_ctl[i][3];
        drive(t_pcif[i], t_ctl[i][2], t_ctl[i][1], t_pe[i], t_ctl[i][0], t_tg[i]);
        tick();
      end
    end
    id_en = 1; exe_en = 1;
    drive(32'h0, 0, 0, 32'h0, 0, 32'h0);
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
